key_event_decoder: RTL and testbench

Classifies the debounced push-button level into single-cycle short-press, double-press, long-press and auto-repeat event pulses. Sits between `key_filter` and `LED_circulate` in the board top. With it, one physical key can drive several LED-rotation commands: step, reverse, start run and fast-step. It is purely sequential: one FSM plus one cycle counter, all in the system clock domain.

---
 rtl/key_event_decoder.sv | 152 +++++++++++++++
 tb/tb_key_event_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into one-cycle short, double, long and repeat pulses.
// One FSM plus one shared cycle counter; the counter restarts on every state change.
module key_event_decoder #(
  parameter int LONG_CYC = 50_000_000,
  parameter int DBL_GAP  = 15_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  input  logic enable,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int MaxLongGap = (LONG_CYC > DBL_GAP) ? LONG_CYC : DBL_GAP;
  localparam int MaxCyc     = (MaxLongGap > REP_CYC) ? MaxLongGap : REP_CYC;
  localparam int CntW       = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] LongCnt = CntW'(LONG_CYC);
  localparam logic [CntW-1:0] GapCnt  = CntW'(DBL_GAP);
  localparam logic [CntW-1:0] RepCnt  = CntW'(REP_CYC);
  localparam logic [CntW-1:0] CntZero = '0;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [3:0] EvNone   = 4'b0000;
  localparam logic [3:0] EvShort  = 4'b1000;
  localparam logic [3:0] EvDouble = 4'b0100;
  localparam logic [3:0] EvLong   = 4'b0010;
  localparam logic [3:0] EvRepeat = 4'b0001;

  typedef enum logic [2:0] {
    REL_WAIT,
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HOLD,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REL_WAIT;
      cnt_q   <= CntZero;
      pulse_q <= EvNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Comparisons use the incremented count so a pulse follows the N-th sample directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = EvNone;
    cnt_inc = cnt_q + CntOne;

    if (!enable) begin
      state_d = REL_WAIT;
      cnt_d   = CntZero;
    end else begin
      case (state_q)
        REL_WAIT: begin
          cnt_d = CntZero;
          if (!key_in) state_d = IDLE;
        end
        IDLE: begin
          cnt_d = CntZero;
          if (key_in) begin
            state_d = PRESS1;
            cnt_d   = CntOne;
          end
        end
        // The long threshold wins even when the key releases on that same sample.
        PRESS1: begin
          if (cnt_inc == LongCnt) begin
            pulse_d = EvLong;
            state_d = HOLD;
            cnt_d   = CntZero;
          end else if (key_in) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = GAP;
            cnt_d   = CntOne;
          end
        end
        // A re-press wins over the gap timeout on the same sample.
        GAP: begin
          if (key_in) begin
            state_d = PRESS2;
            cnt_d   = CntOne;
          end else if (cnt_inc == GapCnt) begin
            pulse_d = EvShort;
            state_d = IDLE;
            cnt_d   = CntZero;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESS2: begin
          if (!key_in) begin
            pulse_d = EvDouble;
            state_d = IDLE;
            cnt_d   = CntZero;
          end else if (cnt_inc == LongCnt) begin
            pulse_d = EvDouble;
            state_d = DRAIN;
            cnt_d   = CntZero;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HOLD: begin
          if (!key_in) begin
            state_d = IDLE;
            cnt_d   = CntZero;
          end else if (cnt_inc == RepCnt) begin
            pulse_d = EvRepeat;
            cnt_d   = CntZero;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DRAIN: begin
          cnt_d = CntZero;
          if (!key_in) state_d = IDLE;
        end
        default: begin
          state_d = REL_WAIT;
          cnt_d   = CntZero;
        end
      endcase
    end
  end

  assign short_pulse  = pulse_q[3];
  assign double_pulse = pulse_q[2];
  assign long_pulse   = pulse_q[1];
  assign repeat_pulse = pulse_q[0];
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: directed key patterns push expected events,
// a negedge monitor pops and compares them whenever any pulse output is high.
module tb_key_event_decoder;

  localparam logic [3:0] EvShort  = 4'b1000;
  localparam logic [3:0] EvDouble = 4'b0100;
  localparam logic [3:0] EvLong   = 4'b0010;
  localparam logic [3:0] EvRepeat = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic key_in;
  logic enable;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;
  logic [3:0] pulses;

  int   cycleCount = 0;
  int   checkCount = 0;
  int   failCount  = 0;
  exp_t expQ[$];

  assign pulses = {short_pulse, double_pulse, long_pulse, repeat_pulse};

  key_event_decoder #(
    .LONG_CYC(8),
    .DBL_GAP (5),
    .REP_CYC (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_in      (key_in),
    .enable      (enable),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Inputs change at a negedge and are sampled by the following posedge.
  task automatic applyStimulus(input logic key, input logic en, input int n);
    for (int i = 0; i < n; i++) begin
      key_in = key;
      enable = en;
      @(negedge clk);
    end
  endtask

  function automatic void expectEvent(input logic [3:0] kind, input int cyc);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    expQ.push_back(e);
  endfunction

  function automatic int nextSample();
    return cycleCount + 1;
  endfunction

  // A pulse caused by the sample at edge E is visible at the negedge where cycleCount == E.
  always @(negedge clk) begin
    exp_t e;
    if (pulses != 4'b0000) begin
      checkOutput("one_event_per_cycle", $countones(pulses), 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", int'(pulses), 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("event_kind", int'(pulses), int'(e.kind));
        checkOutput("event_cycle", cycleCount, e.cyc);
      end
    end else if (expQ.size() != 0 && cycleCount > expQ[0].cyc) begin
      e = expQ.pop_front();
      checkOutput("missed_event", int'(pulses), int'(e.kind));
    end
  end

  initial begin
    int s;
    reset  = 1'b1;
    key_in = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 1);
    checkOutput("reset_pulses", int'(pulses), 0);
    reset = 1'b0;

    // Key held through reset: no event until released, busy until first low sample.
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("held_from_reset_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("release_to_idle_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, 3);

    // Short press: 3 high, short after the 5th low sample.
    s = nextSample();
    expectEvent(EvShort, s + 7);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("press_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("after_short_busy", int'(busy), 0);

    // Double press: 3 high, 2 low, 2 high, release.
    s = nextSample();
    expectEvent(EvDouble, s + 7);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("after_double_busy", int'(busy), 0);

    // Long press with three repeats.
    s = nextSample();
    expectEvent(EvLong,   s + 7);
    expectEvent(EvRepeat, s + 11);
    expectEvent(EvRepeat, s + 15);
    expectEvent(EvRepeat, s + 19);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("after_long_busy", int'(busy), 0);

    // Second press held past the long threshold: double then drain.
    s = nextSample();
    expectEvent(EvDouble, s + 12);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 12);
    checkOutput("drain_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("after_drain_busy", int'(busy), 0);

    // Enable drop mid-press aborts; re-enabled with key held gives nothing.
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("reenable_held_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("reenable_release_busy", int'(busy), 0);
    s = nextSample();
    expectEvent(EvShort, s + 7);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 10);

    // Release on the 8th sample still counts as long.
    s = nextSample();
    expectEvent(EvLong, s + 7);
    applyStimulus(1'b1, 1'b1, 7);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("boundary_long_busy", int'(busy), 0);

    // Re-press on the 5th gap sample still counts as double.
    s = nextSample();
    expectEvent(EvDouble, s + 8);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 8);

    // Reset mid-press: the aborted sequence emits nothing.
    applyStimulus(1'b1, 1'b1, 3);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("mid_reset_busy", int'(busy), 1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("after_mid_reset_busy", int'(busy), 0);

    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
